// File: rtl/sid_bus_pkg.sv
// sid_bus_pkg: shared constants, SID register map and FSM state type for
// the SID write-bus arbiter.
package sid_bus_pkg;

    localparam int unsigned SID_ADDR_W   = 5;
    localparam int unsigned SID_DATA_W   = 8;
    localparam int unsigned SID_NUM_REGS = 25;

    // First read-only register; writes at or above this address are dropped
    localparam logic [SID_ADDR_W-1:0] SID_RO_BASE  = 5'h19;

    localparam logic [SID_ADDR_W-1:0] REG_FREQ_LO  = 5'h00;
    localparam logic [SID_ADDR_W-1:0] REG_CTRL     = 5'h04;
    localparam logic [SID_ADDR_W-1:0] REG_AD       = 5'h05;
    localparam logic [SID_ADDR_W-1:0] REG_SR       = 5'h06;
    localparam logic [SID_ADDR_W-1:0] REG_FC_LO    = 5'h15;
    localparam logic [SID_ADDR_W-1:0] REG_RES_FILT = 5'h17;
    localparam logic [SID_ADDR_W-1:0] REG_MODE_VOL = 5'h18;

    typedef enum logic [1:0] {
        ST_RST    = 2'd0,
        ST_IDLE   = 2'd1,
        ST_STROBE = 2'd2,
        ST_GAP    = 2'd3
    } sid_state_e;

endpackage

// File: rtl/sid_rr_arbiter.sv
// sid_rr_arbiter: round-robin picker over NREQ requesters.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   i_req       - request vector
//   i_advance   - current pick accepted; next search starts after it
//   o_grant_c   - one-hot pick (combinational)
//   o_idx_c     - index of the pick (combinational)
//   o_any_c     - at least one request present (combinational)
module sid_rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  i_req,
    input  logic             i_advance,
    output logic [NREQ-1:0]  o_grant_c,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_any_c
);

    logic [IDX_W-1:0] r_ptr;
    int unsigned      w_cand;

    // Scan from r_ptr upward with wrap; first asserted request wins
    always_comb begin
        o_any_c   = 1'b0;
        o_idx_c   = '0;
        o_grant_c = '0;
        w_cand    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_cand = (32'(r_ptr) + k) % NREQ;
            if (!o_any_c && i_req[IDX_W'(w_cand)]) begin
                o_any_c = 1'b1;
                o_idx_c = IDX_W'(w_cand);
            end
        end
        if (o_any_c) begin
            o_grant_c[o_idx_c] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_idx_c == IDX_W'(NREQ - 1)) ? '0 : o_idx_c + 1'b1;
        end
    end

endmodule

// File: rtl/sid_bus_arbiter.sv
// sid_bus_arbiter: shares the SID write bus between NREQ requesters,
// generates phi2, the SID reset pulse and chip-select write strobes.
// Optional feature macro: SID_SHADOW_EN adds a readable shadow of all
// completed writes (shadow_raddr in, shadow_rdata out).
// Ports:
//   C6_CLK_8MHZ         - board clock
//   sid_reset           - synchronous active-high reset
//   req/req_addr/req_data - per-requester write request, address, data
//   ack                 - one-clock completion pulse to served requester
//   err                 - one-clock pulse when a read-only write is dropped
//   ready               - idle with SID out of reset
//   SID_CLK, SID_NOTRES, SID_NOTCS, SID_ADDR, SID_DATA - SID pins
module sid_bus_arbiter
    import sid_bus_pkg::*;
#(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned CLKDIV_LOG2  = 4,
    parameter int unsigned RESET_CYCLES = 16
) (
    input  logic                       C6_CLK_8MHZ,
    input  logic                       sid_reset,
    input  logic [NREQ-1:0]            req,
    input  logic [SID_ADDR_W*NREQ-1:0] req_addr,
    input  logic [SID_DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]            ack,
    output logic                       err,
    output logic                       ready,
    output logic                       SID_CLK,
    output logic                       SID_NOTRES,
    output logic                       SID_NOTCS,
    output logic [SID_ADDR_W-1:0]      SID_ADDR,
    output logic [SID_DATA_W-1:0]      SID_DATA
`ifdef SID_SHADOW_EN
    ,
    input  logic [SID_ADDR_W-1:0]      shadow_raddr,
    output logic [SID_DATA_W-1:0]      shadow_rdata
`endif
);

    localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned RCNT_W = $clog2(RESET_CYCLES);
    localparam logic [CLKDIV_LOG2-1:0] DIV_LAST = CLKDIV_LOG2'(2**CLKDIV_LOG2 - 1);
    localparam logic [CLKDIV_LOG2-1:0] DIV_PRE  = CLKDIV_LOG2'(2**CLKDIV_LOG2 - 2);

    logic [CLKDIV_LOG2-1:0] r_div_cnt;
    sid_state_e             r_state, w_state_nxt;
    logic [RCNT_W-1:0]      r_rst_cnt, w_rst_cnt_nxt;
    logic [IDX_W-1:0]       r_win_idx, w_win_nxt;
    logic                   r_notres, w_notres_nxt;
    logic                   r_notcs, w_notcs_nxt;
    logic [SID_ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [SID_DATA_W-1:0]  r_data, w_data_nxt;
    logic [NREQ-1:0]        r_ack, w_ack_nxt;
    logic                   r_err, w_err_nxt;
    logic                   r_ready, w_ready_nxt;

    logic                   w_tick, w_pre_tick, w_advance, w_any;
    logic [NREQ-1:0]        w_grant;
    logic [IDX_W-1:0]       w_idx;
    logic [SID_ADDR_W-1:0]  w_sel_addr;
    logic [SID_DATA_W-1:0]  w_sel_data;

    assign w_tick     = (r_div_cnt == DIV_LAST);
    assign w_pre_tick = (r_div_cnt == DIV_PRE);

    sid_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk       (C6_CLK_8MHZ),
        .rst       (sid_reset),
        .i_req     (req),
        .i_advance (w_advance),
        .o_grant_c (w_grant),
        .o_idx_c   (w_idx),
        .o_any_c   (w_any)
    );

    // Address/data of the current pick
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_sel_addr = req_addr[i*SID_ADDR_W +: SID_ADDR_W];
                w_sel_data = req_data[i*SID_DATA_W +: SID_DATA_W];
            end
        end
    end

    // Next state / next outputs; all transitions on tick. GAP's closing tick
    // arbitrates like IDLE so back-to-back writes run every two phi2 periods.
    always_comb begin
        w_state_nxt   = r_state;
        w_rst_cnt_nxt = r_rst_cnt;
        w_win_nxt     = r_win_idx;
        w_notres_nxt  = r_notres;
        w_notcs_nxt   = r_notcs;
        w_addr_nxt    = r_addr;
        w_data_nxt    = r_data;
        w_ack_nxt     = '0;
        w_err_nxt     = 1'b0;
        w_advance     = 1'b0;
        unique case (r_state)
            ST_RST: begin
                if (w_tick) begin
                    if (r_rst_cnt == RCNT_W'(RESET_CYCLES - 1)) begin
                        w_state_nxt   = ST_IDLE;
                        w_notres_nxt  = 1'b1;
                        w_rst_cnt_nxt = '0;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                    end
                end
            end
            ST_IDLE, ST_GAP: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    if (w_any) begin
                        w_advance = 1'b1;
                        if (w_sel_addr < SID_RO_BASE) begin
                            w_state_nxt = ST_STROBE;
                            w_notcs_nxt = 1'b0;
                            w_addr_nxt  = w_sel_addr;
                            w_data_nxt  = w_sel_data;
                            w_win_nxt   = w_idx;
                        end else begin
                            w_ack_nxt = w_grant;
                            w_err_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_STROBE: begin
                // ack registered one clock early so it coincides with the tick
                if (w_pre_tick) begin
                    w_ack_nxt = NREQ'(1) << r_win_idx;
                end
                if (w_tick) begin
                    w_notcs_nxt = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
        w_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge C6_CLK_8MHZ) begin
        if (sid_reset) begin
            r_div_cnt <= '0;
            r_state   <= ST_RST;
            r_rst_cnt <= '0;
            r_win_idx <= '0;
            r_notres  <= 1'b0;
            r_notcs   <= 1'b1;
            r_addr    <= '0;
            r_data    <= '0;
            r_ack     <= '0;
            r_err     <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            r_state   <= w_state_nxt;
            r_rst_cnt <= w_rst_cnt_nxt;
            r_win_idx <= w_win_nxt;
            r_notres  <= w_notres_nxt;
            r_notcs   <= w_notcs_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign SID_CLK    = r_div_cnt[CLKDIV_LOG2-1];
    assign SID_NOTRES = r_notres;
    assign SID_NOTCS  = r_notcs;
    assign SID_ADDR   = r_addr;
    assign SID_DATA   = r_data;
    assign ack        = r_ack;
    assign err        = r_err;
    assign ready      = r_ready;

`ifdef SID_SHADOW_EN
    logic [SID_DATA_W-1:0] r_shadow [SID_NUM_REGS];

    // Captured at the end of the ack clock of each completed write
    always_ff @(posedge C6_CLK_8MHZ) begin
        if (sid_reset) begin
            for (int unsigned i = 0; i < SID_NUM_REGS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (r_state == ST_STROBE && w_tick) begin
            r_shadow[r_addr] <= r_data;
        end
    end

    assign shadow_rdata = (shadow_raddr < SID_RO_BASE) ? r_shadow[shadow_raddr] : '0;
`endif

endmodule

// File: tb/tb_sid_bus_arbiter.sv
// tb_sid_bus_arbiter: directed, table-driven bench for sid_bus_arbiter.
module tb_sid_bus_arbiter;
    import sid_bus_pkg::*;

    logic        clk;
    logic        sid_reset;
    logic [3:0]  req;
    logic [19:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        err, ready, sid_clk, notres, notcs;
    logic [4:0]  sid_addr;
    logic [7:0]  sid_data;
`ifdef SID_SHADOW_EN
    logic [4:0]  shadow_raddr;
    logic [7:0]  shadow_rdata;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int ack_events = 0;
    int m_div = 0;

    sid_bus_arbiter dut (
        .C6_CLK_8MHZ (clk),
        .sid_reset   (sid_reset),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .ack         (ack),
        .err         (err),
        .ready       (ready),
        .SID_CLK     (sid_clk),
        .SID_NOTRES  (notres),
        .SID_NOTCS   (notcs),
        .SID_ADDR    (sid_addr),
        .SID_DATA    (sid_data)
`ifdef SID_SHADOW_EN
        ,
        .shadow_raddr (shadow_raddr),
        .shadow_rdata (shadow_rdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference phi2 divider
    always @(posedge clk) begin
        if (sid_reset) m_div <= 0;
        else           m_div <= (m_div + 1) % 16;
    end

    always @(negedge clk) begin
        if (ack != 4'b0000) ack_events++;
    end

    typedef struct {
        int         idx;
        logic [4:0] addr;
        logic [7:0] data;
        logic [3:0] exp_ack;
        logic       exp_err;
        int         exp_cs;
        int         exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 sid_reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 sid_reset = 1'b0;
    endtask

    task automatic wait_div(input int v);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (m_div != v && n < 64);
        if (n >= 64) chk("wait_div_timeout", 32'(n), 32'(0));
    endtask

    // Counts SID_NOTRES-low clocks from reset release and checks the pins around it
    task automatic rst_seq_check(input string tag);
        int  low, n, clk_bad, a0;
        bit  done, cs_bad;
        low = 0; n = 0; clk_bad = 0; done = 0; cs_bad = 0;
        a0 = ack_events;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
            if (notcs !== 1'b1) cs_bad = 1;
            if (sid_clk !== (m_div >= 8)) clk_bad++;
            if (notres === 1'b0) low++;
            else done = 1;
        end
        chk({tag, "_notres_high"}, 32'(notres), 32'(1));
        chk({tag, "_notres_low_clocks"}, 32'(low), 32'(256));
        chk({tag, "_notcs_held"}, 32'(cs_bad), 32'(0));
        chk({tag, "_sid_clk_phase"}, 32'(clk_bad), 32'(0));
        chk({tag, "_ready"}, 32'(ready), 32'(1));
        chk({tag, "_no_ack"}, 32'(ack_events - a0), 32'(0));
    endtask

    initial begin
        int last, n, t, k, cs_n, ack_k, ev0;
        bit got, addr_ok, err_seen, err_at;
        logic [3:0] ack_v;

        sid_reset = 1'b1;
        req = '0;
        req_addr = '0;
        req_data = '0;
`ifdef SID_SHADOW_EN
        shadow_raddr = '0;
`endif
        vecs[0] = '{0, REG_MODE_VOL, 8'h0F, 4'b0001, 1'b0, 16, 28};
        vecs[1] = '{1, REG_CTRL,     8'h11, 4'b0010, 1'b0, 16, 28};
        vecs[2] = '{2, 5'h1B,        8'h55, 4'b0100, 1'b1, 0,  13};
        vecs[3] = '{3, REG_FREQ_LO,  8'hA5, 4'b1000, 1'b0, 16, 28};
        vecs[4] = '{2, 5'h19,        8'h01, 4'b0100, 1'b1, 0,  13};
        vecs[5] = '{1, 5'h1F,        8'hFF, 4'b0010, 1'b1, 0,  13};
        vecs[6] = '{3, REG_RES_FILT, 8'h3C, 4'b1000, 1'b0, 16, 28};

        // Reset values while sid_reset is high
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sid_clk", 32'(sid_clk), 32'(0));
        chk("rst_notres", 32'(notres), 32'(0));
        chk("rst_notcs", 32'(notcs), 32'(1));
        chk("rst_addr", 32'(sid_addr), 32'(0));
        chk("rst_data", 32'(sid_data), 32'(0));
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_ready", 32'(ready), 32'(0));
        repeat (2) @(posedge clk);
        #1 sid_reset = 1'b0;
        rst_seq_check("init");

        // Round-robin with all requesters held
        for (int i = 0; i < 4; i++) begin
            req_addr[5*i +: 5] = REG_SR + 5'(i);
            req_data[8*i +: 8] = 8'h40 + 8'(i);
        end
        @(posedge clk);
        #1 req = 4'b1111;
        last = 0; n = 0; t = 0;
        while (n < 8 && t < 400) begin
            @(negedge clk);
            t++;
            if (ack != 4'b0000) begin
                chk($sformatf("rr_order_%0d", n), 32'(ack), 32'(1) << (n % 4));
                if (n > 0) chk($sformatf("rr_spacing_%0d", n), 32'(t - last), 32'(32));
                last = t;
                n++;
            end
        end
        chk("rr_ack_count", 32'(n), 32'(8));
        @(posedge clk);
        #1 req = '0;

        // Table of single-requester transactions, req raised at div_cnt=3
        for (int v = 0; v < 7; v++) begin
            wait_div(3);
            req_addr[5*vecs[v].idx +: 5] = vecs[v].addr;
            req_data[8*vecs[v].idx +: 8] = vecs[v].data;
            req[vecs[v].idx] = 1'b1;
            k = 0; got = 0; cs_n = 0; addr_ok = 1; err_seen = 0; err_at = 0;
            ack_v = '0; ack_k = -1;
            while (!got && k < 64) begin
                @(negedge clk);
                if (notcs === 1'b0) begin
                    cs_n++;
                    if (sid_addr !== vecs[v].addr || sid_data !== vecs[v].data) addr_ok = 0;
                end
                if (err === 1'b1) err_seen = 1;
                if (ack != 4'b0000) begin
                    got = 1; ack_v = ack; ack_k = k; err_at = err;
                end else begin
                    k++;
                end
            end
            @(posedge clk);
            #1 req[vecs[v].idx] = 1'b0;
            chk($sformatf("v%0d_ack", v), 32'(ack_v), 32'(vecs[v].exp_ack));
            chk($sformatf("v%0d_latency", v), 32'(ack_k), 32'(vecs[v].exp_lat));
            chk($sformatf("v%0d_err", v), 32'(err_at), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_err_seen", v), 32'(err_seen), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_cs_clocks", v), 32'(cs_n), 32'(vecs[v].exp_cs));
            chk($sformatf("v%0d_addr_data", v), 32'(addr_ok), 32'(1));
            chk($sformatf("v%0d_cs_release", v), 32'(notcs), 32'(1));
            chk($sformatf("v%0d_ack_single", v), 32'(ack), 32'(0));
        end

`ifdef SID_SHADOW_EN
        shadow_raddr = REG_CTRL;
        #1 chk("shadow_ctrl", 32'(shadow_rdata), 32'h11);
        shadow_raddr = REG_MODE_VOL;
        #1 chk("shadow_mode_vol", 32'(shadow_rdata), 32'h0F);
        shadow_raddr = 5'h1B;
        #1 chk("shadow_ro_zero", 32'(shadow_rdata), 32'h00);
`endif

        // Reset 6 clocks into STROBE aborts the write
        ev0 = ack_events;
        wait_div(3);
        req_addr[4:0] = REG_AD;
        req_data[7:0] = 8'h77;
        req[0] = 1'b1;
        got = 0; k = 0;
        while (!got && k < 64) begin
            @(negedge clk);
            k++;
            if (notcs === 1'b0) got = 1;
        end
        chk("abort_cs_seen", 32'(got), 32'(1));
        repeat (5) @(posedge clk);
        do_reset(1);
        req = '0;
        chk("abort_notcs", 32'(notcs), 32'(1));
        chk("abort_notres", 32'(notres), 32'(0));
        chk("abort_addr", 32'(sid_addr), 32'(0));
        chk("abort_data", 32'(sid_data), 32'(0));
        chk("abort_ready", 32'(ready), 32'(0));
        rst_seq_check("replay");
        chk("abort_no_ack", 32'(ack_events - ev0), 32'(0));

`ifdef SID_SHADOW_EN
        shadow_raddr = REG_CTRL;
        #1 chk("shadow_cleared", 32'(shadow_rdata), 32'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
